// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by the memory/write-back stage.
// The helpers classify an icode by the kind of data-memory access it makes.
package y86_pkg;

    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;

    localparam logic [1:0] AOK = 2'd0;
    localparam logic [1:0] HLT = 2'd1;
    localparam logic [1:0] ADR = 2'd2;
    localparam logic [1:0] INS = 2'd3;

    localparam logic [3:0] RNONE = 4'hF;

    function automatic logic is_mem_read(input logic [3:0] icode);
        return (icode == MRMOVQ) || (icode == POPQ) || (icode == RET);
    endfunction

    function automatic logic is_mem_write(input logic [3:0] icode);
        return (icode == RMMOVQ) || (icode == PUSHQ) || (icode == CALL);
    endfunction

    // Pops and returns read through the old stack pointer carried in valA.
    function automatic logic addr_from_vala(input logic [3:0] icode);
        return (icode == POPQ) || (icode == RET);
    endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Two-state data-memory handshake: issues req, holds it until ack, and
// reports busy while the access is outstanding. Ack may land in the request cycle.
module mem_access_fsm (
    input  logic clk,
    input  logic rst_n,
    input  logic access_i,
    input  logic ack_i,
    output logic req_o,
    output logic busy_o
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0] state_q;
    logic [0:0] state_d;

    // Gating with rst_n drops req in the very cycle reset asserts, so a late ack is never seen.
    assign req_o  = rst_n && ((state_q == S_WAIT) || access_i);
    assign busy_o = req_o && !ack_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (access_i && !ack_i) state_d = S_WAIT;
            S_WAIT:  if (ack_i)              state_d = S_IDLE;
            default:                         state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Y86-64 memory stage plus the W pipeline register. Address checking and
// status live here; the request/ack sequencing lives in mem_access_fsm.
module mem_wb_stage
    import y86_pkg::*;
#(
    parameter int DMEM_BYTES = 1024,
    parameter int XLEN       = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      M_stat,
    input  logic [3:0]      M_icode,
    input  logic            M_cnd,
    input  logic [XLEN-1:0] M_valE,
    input  logic [XLEN-1:0] M_valA,
    input  logic [3:0]      M_dstE,
    input  logic [3:0]      M_dstM,
    input  logic            W_stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ack,
    output logic [1:0]      m_stat,
    output logic [XLEN-1:0] m_valM,
    output logic            mem_busy,
    output logic [1:0]      W_stat,
    output logic [3:0]      W_icode,
    output logic [XLEN-1:0] W_valE,
    output logic [XLEN-1:0] W_valM,
    output logic [3:0]      W_dstE,
    output logic [3:0]      W_dstM
);

    // Highest legal start address for an 8-byte access.
    localparam logic [XLEN-1:0] ADDR_MAX = XLEN'(DMEM_BYTES - 8);

    logic            rd_op;
    logic            wr_op;
    logic            eligible;
    logic            addr_err;
    logic            access;
    logic [XLEN-1:0] addr;
    logic            unused_cnd;

    assign unused_cnd = M_cnd;

    assign rd_op    = is_mem_read(M_icode);
    assign wr_op    = is_mem_write(M_icode);
    assign addr     = addr_from_vala(M_icode) ? M_valA : M_valE;
    assign eligible = (rd_op || wr_op) && (M_stat == AOK);
    assign addr_err = eligible && (addr > ADDR_MAX);
    assign access   = eligible && !addr_err;

    mem_access_fsm u_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .access_i (access),
        .ack_i    (dmem_ack),
        .req_o    (dmem_req),
        .busy_o   (mem_busy)
    );

    assign dmem_we    = wr_op;
    assign dmem_addr  = addr;
    assign dmem_wdata = M_valA;

    assign m_stat = addr_err ? ADR : M_stat;
    assign m_valM = (dmem_req && !dmem_we && dmem_ack) ? dmem_rdata : '0;

    // Stall holds W outright; otherwise an outstanding access becomes a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            W_stat  <= AOK;
            W_icode <= NOP;
            W_valE  <= '0;
            W_valM  <= '0;
            W_dstE  <= RNONE;
            W_dstM  <= RNONE;
        end else if (W_stall) begin
            W_stat  <= W_stat;
            W_icode <= W_icode;
            W_valE  <= W_valE;
            W_valM  <= W_valM;
            W_dstE  <= W_dstE;
            W_dstM  <= W_dstM;
        end else if (mem_busy) begin
            W_stat  <= AOK;
            W_icode <= NOP;
            W_valE  <= '0;
            W_valM  <= '0;
            W_dstE  <= RNONE;
            W_dstM  <= RNONE;
        end else begin
            W_stat  <= m_stat;
            W_icode <= M_icode;
            W_valE  <= M_valE;
            W_valM  <= m_valM;
            W_dstE  <= M_dstE;
            W_dstM  <= M_dstM;
        end
    end

endmodule
